// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path, transmit path and the receive
// byte buffer.
//   uart_byte_t         : one UART data byte
//   UART_RX_FIFO_DEPTH  : default number of entries in the receive buffer
//   fill_state_e        : logical occupancy of a byte buffer (EMPTY/PARTIAL/FULL)
//   fill_state_of()     : maps an occupancy count onto fill_state_e
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef logic [7:0] uart_byte_t;

   localparam int UART_RX_FIFO_DEPTH = 16;

   typedef enum logic [1:0] {
      FILL_EMPTY,
      FILL_PARTIAL,
      FILL_FULL
   } fill_state_e;

   function automatic fill_state_e fill_state_of(input int lvl, input int depth);
      if (lvl == 0)
         return FILL_EMPTY;
      else if (lvl >= depth)
         return FILL_FULL;
      else
         return FILL_PARTIAL;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side circular byte buffer behind the UART receiver. Bytes arrive on a
// one-cycle write strobe (no backpressure is possible) and leave on a
// first-word-fall-through valid/ready interface. Bytes arriving while the
// buffer is full and not being drained are dropped and flagged in a sticky
// overflow bit.
//
// Optional feature macro: UART_RX_FIFO_AFULL_EN adds the afull output
// (level >= AFULL_THRESH), intended for XOFF generation.
//
// Parameters:
//   DEPTH         number of byte entries, power of two, >= 2
//   AFULL_THRESH  almost-full threshold 1..DEPTH (afull build only)
// Ports:
//   clk        clock
//   rst        asynchronous, active-high reset
//   in_data    received byte, captured when in_valid is high
//   in_valid   write strobe, one write per high cycle
//   out_data   head-of-queue byte, valid when out_valid is high
//   out_valid  buffer non-empty
//   out_ready  consumer takes the head byte when out_valid & out_ready
//   level      number of stored bytes, 0..DEPTH
//   overflow   sticky lost-byte flag
//   ovf_clr    synchronous clear of overflow (a simultaneous drop wins)
//   afull      (UART_RX_FIFO_AFULL_EN only) level >= AFULL_THRESH
// -----------------------------------------------------------------------------
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH        = UART_RX_FIFO_DEPTH,
   parameter int AFULL_THRESH = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  uart_byte_t             in_data,
   input  logic                   in_valid,
   output uart_byte_t             out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   input  logic                   ovf_clr
`ifdef UART_RX_FIFO_AFULL_EN
   ,
   output logic                   afull
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   // Elaboration-time sanity check of the configuration.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
       AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_param_check
      $error("uart_rx_fifo: illegal DEPTH/AFULL_THRESH");
   end

   uart_byte_t        mem [DEPTH];
   logic [AW-1:0]     wr_ptr_reg;
   logic [AW-1:0]     rd_ptr_reg;
   logic [LW-1:0]     level_reg;
   logic [LW-1:0]     level_next;
   logic              overflow_reg;
   fill_state_e       fill_state;
   logic              full;
   logic              push;
   logic              pop;
   logic              drop;

   assign fill_state = fill_state_of(int'(level_reg), DEPTH);
   assign full       = (fill_state == FILL_FULL);
   assign out_valid  = (fill_state != FILL_EMPTY);

   // A full buffer still accepts a byte when the head leaves in the same
   // cycle, so a continuously drained buffer never drops data.
   assign pop  = out_valid & out_ready;
   assign push = in_valid & (~full | pop);
   assign drop = in_valid & full & ~pop;

   // Storage has no reset; only the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= in_data;
   end

   assign out_data = mem[rd_ptr_reg];

   always_comb begin
      level_next = level_reg;
      if (push && !pop)
         level_next = level_reg + LW'(1);
      else if (pop && !push)
         level_next = level_reg - LW'(1);
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         level_reg <= level_next;
         // A drop in the same cycle as a clear keeps the flag set.
         if (drop)
            overflow_reg <= 1'b1;
         else if (ovf_clr)
            overflow_reg <= 1'b0;
      end
   end

   assign level    = level_reg;
   assign overflow = overflow_reg;

`ifdef UART_RX_FIFO_AFULL_EN
   assign afull = (level_reg >= LW'(AFULL_THRESH));
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo. A queue-based reference model tracks
// the stored bytes and the overflow flag; every cycle the DUT outputs are
// compared with it, and directed scenarios add explicit constant checks.
// Build with UART_RX_FIFO_AFULL_EN defined to also exercise afull.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

   localparam int DEPTH        = 16;
   localparam int AFULL_THRESH = 12;
   localparam int LW           = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    in_data;
   logic          in_valid;
   logic [7:0]    out_data;
   logic          out_valid;
   logic          out_ready;
   logic [LW-1:0] level;
   logic          overflow;
   logic          ovf_clr;
`ifdef UART_RX_FIFO_AFULL_EN
   logic          afull;
`endif

   uart_rx_fifo #(
      .DEPTH        (DEPTH),
      .AFULL_THRESH (AFULL_THRESH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr)
`ifdef UART_RX_FIFO_AFULL_EN
      ,
      .afull     (afull)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: the buffer is simply an ordered list of bytes.
   logic [7:0] model_q[$];
   logic       model_ovf;
   int         checks   = 0;
   int         failures = 0;
   int         txn      = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".level"},     32'(level),     32'(model_q.size()));
      check({tag, ".out_valid"}, 32'(out_valid), 32'(model_q.size() != 0));
      if (model_q.size() != 0)
         check({tag, ".out_data"}, 32'(out_data), 32'(model_q[0]));
      check({tag, ".overflow"},  32'(overflow),  32'(model_ovf));
`ifdef UART_RX_FIFO_AFULL_EN
      check({tag, ".afull"},     32'(afull),     32'(model_q.size() >= AFULL_THRESH));
`endif
   endtask

   // One clock cycle with the given inputs; model updated from pre-edge state.
   task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic c);
      bit pop_m;
      bit push_m;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      ovf_clr   = c;
      pop_m  = (model_q.size() != 0) && r;
      push_m = v && ((model_q.size() < DEPTH) || pop_m);
      @(posedge clk);
      if (pop_m)
         void'(model_q.pop_front());
      if (push_m)
         model_q.push_back(d);
      if (v && !push_m)
         model_ovf = 1'b1;
      else if (c)
         model_ovf = 1'b0;
      #1;
      txn++;
      $display("txn %0d v=%0b d=%02h r=%0b c=%0b level=%0d ovf=%0b", txn, v, d, r, c, level, overflow);
      check_state("cyc");
      in_valid  = 1'b0;
      out_ready = 1'b0;
      ovf_clr   = 1'b0;
   endtask

   task automatic fill_seq(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++)
         cycle(1'b1, base + 8'(i), 1'b0, 1'b0);
   endtask

   task automatic drain_all();
      while (model_q.size() != 0)
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] b;
      int         pv;
      int         pr;

      rst       = 1'b1;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      ovf_clr   = 1'b0;
      model_ovf = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.level",     32'(level),     32'd0);
      check("reset.out_valid", 32'(out_valid), 32'd0);
      check("reset.overflow",  32'(overflow),  32'd0);
`ifdef UART_RX_FIFO_AFULL_EN
      check("reset.afull",     32'(afull),     32'd0);
`endif
      #2 rst = 1'b0;

      // Three pushes, then drain in order.
      cycle(1'b1, 8'h41, 1'b0, 1'b0);
      cycle(1'b1, 8'h42, 1'b0, 1'b0);
      cycle(1'b1, 8'h43, 1'b0, 1'b0);
      check("t1.level",     32'(level),     32'd3);
      check("t1.out_valid", 32'(out_valid), 32'd1);
      check("t1.head",      32'(out_data),  32'h41);
      for (int i = 0; i < 3; i++) begin
         check("t1.read", 32'(out_data), 32'h41 + 32'(i));
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
      end
      check("t1.empty_level", 32'(level),     32'd0);
      check("t1.empty_valid", 32'(out_valid), 32'd0);

      // Fill, drop one, drain, clear.
      fill_seq(8'h00, 16);
      cycle(1'b1, 8'hAA, 1'b0, 1'b0);
      check("t2.level",    32'(level),    32'd16);
      check("t2.overflow", 32'(overflow), 32'd1);
      for (int i = 0; i < 16; i++) begin
         check("t2.read", 32'(out_data), 32'(i));
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
      end
      check("t2.empty", 32'(out_valid), 32'd0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      check("t2.ovf_clr", 32'(overflow), 32'd0);

      // Full with simultaneous push and pop.
      fill_seq(8'h00, 16);
      cycle(1'b1, 8'h55, 1'b1, 1'b0);
      check("t3.overflow", 32'(overflow), 32'd0);
      check("t3.level",    32'(level),    32'd16);
      check("t3.head",     32'(out_data), 32'h01);
      for (int i = 0; i < 16; i++) begin
         check("t3.read", 32'(out_data), (i < 15) ? 32'(i + 1) : 32'h55);
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
      end

      // Wrap-around streaming at full throughput.
      cycle(1'b1, 8'hC0, 1'b0, 1'b0);
      for (int i = 1; i < 40; i++) begin
         check("t4.stream", 32'(out_data), 32'hC0 + 32'(i - 1));
         cycle(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0);
         check("t4.level_le1", 32'(level <= LW'(1)), 32'd1);
      end
      drain_all();

      // Clear racing a drop, then reset mid-drain.
      fill_seq(8'h20, 16);
      cycle(1'b1, 8'h99, 1'b0, 1'b1);
      check("t5.set_wins", 32'(overflow), 32'd1);
      for (int i = 0; i < 11; i++)
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("t5.level5", 32'(level), 32'd5);
      #2 rst = 1'b1;
      #1;
      check("t5.rst_level",    32'(level),     32'd0);
      check("t5.rst_valid",    32'(out_valid), 32'd0);
      check("t5.rst_overflow", 32'(overflow),  32'd0);
      model_q.delete();
      model_ovf = 1'b0;
      #4 rst = 1'b0;
      cycle(1'b1, 8'h77, 1'b0, 1'b0);
      check("t5.after_rst", 32'(out_data), 32'h77);
      drain_all();

`ifdef UART_RX_FIFO_AFULL_EN
      // Almost-full threshold.
      fill_seq(8'h60, 11);
      check("t6.afull11", 32'(afull), 32'd0);
      cycle(1'b1, 8'h6B, 1'b0, 1'b0);
      check("t6.afull12", 32'(afull), 32'd1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("t6.afull_pop", 32'(afull), 32'd0);
      drain_all();
`endif

      // Randomized traffic with varying fill pressure.
      for (int ph = 0; ph < 3; ph++) begin
         pv = (ph == 0) ? 80 : (ph == 1) ? 50 : 30;
         pr = (ph == 0) ? 30 : (ph == 1) ? 50 : 80;
         for (int i = 0; i < 800; i++) begin
            b = 8'($urandom);
            cycle(($urandom_range(99) < pv), b, ($urandom_range(99) < pr),
                  ($urandom_range(99) < 5));
         end
      end
      drain_all();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
